// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction memory,
// and buffers {pc, instruction} pairs in a small FIFO that decode drains over valid/ready.
// A redirect from execute reloads the PC and flushes the FIFO.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     data_mem_q [FIFO_DEPTH];
  logic [31:0]     pc_mem_q   [FIFO_DEPTH];
  logic            push, pop;

  // Target is always word aligned; the low bits are deliberately dropped.
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^redirect_target[1:0];

  // Head outputs come only from registered state; they read zero when empty.
  always_comb begin
    instr_valid  = (count_q != '0);
    instr_data   = instr_valid ? data_mem_q[rd_ptr_q] : 32'h0;
    instr_pc     = instr_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
    imem_address = pc_q;
  end

  // Next-state for PC, pointers and count; redirect overrides push and pop.
  always_comb begin
    pop      = instr_valid & instr_ready;
    // A full FIFO may still push when its head leaves in the same cycle.
    push     = fetch_enable & ~redirect_valid & ((count_q < DepthCnt) | pop);
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_target[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_VECTOR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only observed while counted valid, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= imem_data;
      pc_mem_q[wr_ptr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_enable;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  int vectors = 0;
  int miscompares = 0;

  instruction_fetch_unit #(
    .RESET_VECTOR(RV),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_enable   (fetch_enable),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  assign imem_data = imem_address ^ MASK;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic fe, input logic rdy);
    rst_n = 1'b0;
    fetch_enable = fe;
    instr_ready = rdy;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    step();
    step();
  endtask

  task automatic test_reset();
    hold_reset(1'b1, 1'b1);
    vectors++; if (instr_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_valid got %0b want 0", instr_valid); end
    vectors++; if (imem_address !== RV) begin miscompares++;
      $display("FAIL reset_addr got %h want %h", imem_address, RV); end
    vectors++; if (instr_data !== 32'h0) begin miscompares++;
      $display("FAIL reset_data got %h want 0", instr_data); end
    vectors++; if (instr_pc !== 32'h0) begin miscompares++;
      $display("FAIL reset_pc got %h want 0", instr_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_pc = 32'(4 * i);
      vectors++; if (instr_valid !== 1'b1) begin miscompares++;
        $display("FAIL stream_valid[%0d] got %0b want 1", i, instr_valid); end
      vectors++; if (instr_pc !== exp_pc) begin miscompares++;
        $display("FAIL stream_pc[%0d] got %h want %h", i, instr_pc, exp_pc); end
      vectors++; if (instr_data !== (exp_pc ^ MASK)) begin miscompares++;
        $display("FAIL stream_data[%0d] got %h want %h", i, instr_data, exp_pc ^ MASK); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    hold_reset(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vectors++; if (imem_address !== 32'h8) begin miscompares++;
      $display("FAIL bp_addr got %h want 00000008", imem_address); end
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin miscompares++;
      $display("FAIL bp_head got v=%0b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(4 * i);
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc ||
                     instr_data !== (exp_pc ^ MASK)) begin miscompares++;
        $display("FAIL bp_drain[%0d] got v=%0b pc=%h d=%h want pc=%h d=%h", i, instr_valid,
                 instr_pc, instr_data, exp_pc, exp_pc ^ MASK); end
      step();
    end
  endtask

  task automatic test_redirect();
    hold_reset(1'b1, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    vectors++; if (imem_address !== 32'h100 || instr_valid !== 1'b0) begin miscompares++;
      $display("FAIL redir_flush got a=%h v=%0b want a=00000100 v=0", imem_address, instr_valid);
    end
    step();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 ||
                   instr_data !== (32'h100 ^ MASK)) begin miscompares++;
      $display("FAIL redir_first got v=%0b pc=%h d=%h want pc=00000100", instr_valid, instr_pc,
               instr_data); end
    // Redirect while the head is being popped.
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0202;
    step();
    redirect_valid = 1'b0;
    vectors++; if (imem_address !== 32'h200 || instr_valid !== 1'b0) begin miscompares++;
      $display("FAIL redir_pop got a=%h v=%0b want a=00000200 v=0", imem_address, instr_valid);
    end
    step();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin miscompares++;
      $display("FAIL redir_pop_first got v=%0b pc=%h want pc=00000200", instr_valid, instr_pc);
    end
    step();
    vectors++; if (instr_pc !== 32'h204) begin miscompares++;
      $display("FAIL redir_pop_next got pc=%h want 00000204", instr_pc); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc;
    instr_ready = 1'b1;
    fetch_enable = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc ||
                     instr_data !== (exp_pc ^ MASK)) begin miscompares++;
        $display("FAIL wrap[%0d] got v=%0b pc=%h d=%h want pc=%h", i, instr_valid, instr_pc,
                 instr_data, exp_pc); end
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b1;
    fetch_enable = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    step();
    vectors++; if (instr_pc !== 32'h40 || imem_address !== 32'h44) begin miscompares++;
      $display("FAIL stall_pre got pc=%h a=%h want pc=00000040 a=00000044", instr_pc,
               imem_address); end
    fetch_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (instr_valid !== 1'b0 || imem_address !== 32'h44) begin miscompares++;
        $display("FAIL stall[%0d] got v=%0b a=%h want v=0 a=00000044", i, instr_valid,
                 imem_address); end
    end
    fetch_enable = 1'b1;
    step();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h44) begin miscompares++;
      $display("FAIL stall_resume got v=%0b pc=%h want pc=00000044", instr_valid, instr_pc); end
    step();
    vectors++; if (instr_pc !== 32'h48) begin miscompares++;
      $display("FAIL stall_resume2 got pc=%h want 00000048", instr_pc); end
  endtask

  task automatic test_async_reset();
    hold_reset(1'b1, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    step();
    vectors++; if (instr_valid !== 1'b1 || imem_address !== 32'h8) begin miscompares++;
      $display("FAIL areset_pre got v=%0b a=%h want v=1 a=00000008", instr_valid, imem_address);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (instr_valid !== 1'b0 || imem_address !== RV) begin miscompares++;
      $display("FAIL areset got v=%0b a=%h want v=0 a=%h", instr_valid, imem_address, RV); end
    vectors++; if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin miscompares++;
      $display("FAIL areset_head got d=%h pc=%h want 0", instr_data, instr_pc); end
    step();
    rst_n = 1'b1;
    step();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== RV) begin miscompares++;
      $display("FAIL areset_restart got v=%0b pc=%h want pc=%h", instr_valid, instr_pc, RV); end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_enable = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_pc_wrap();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
